spi_word_serializer: RTL and testbench
======================================

Name: spi_word_serializer

Overview:
- SPI slave transmit side: reads parallel words from the SPI word buffer and shifts them out on MISO, MSB-first, SPI mode 0.
- Runs entirely in the system clock domain.
- Samples master sclk/cs through synchronizers.
- Drives the buffer's output-advance strobe one pulse per word.
- Counterpart of the buffer's write-fed receive path: consumes the prefetched buffer output instead of filling it.

Parameters:
- DATA_WIDTH, 32, bits per SPI word; equals buffer DATA_WIDTH.
- FRAME_WORDS, 10, words per frame; equals buffer BUF_SIZE.
- SYNC_STAGES, 2, synchronizer flops on sclk and cs (minimum 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- sclk  in  1  SPI clock from master, asynchronous.
- cs  in  1  SPI chip select from master, active-low, asynchronous.
- miso  out  1  serial data to master.
- buf_data  in  DATA_WIDTH  buffer data_out; current word, prefetched.
- buf_oe  out  1  one-cycle pulse that advances the buffer to the next word.
- buf_rewind  out  1  one-cycle pulse that resets the buffer address to 0; wired to buffer rst.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse after the last bit of word FRAME_WORDS-1 has shifted out.

Behaviour:
- Reset (rst==0 at a clk edge):
  - Outputs: miso=0, buf_oe=0, buf_rewind=0, busy=0, frame_done=0.
  - State: IDLE; counters 0; synchronizers load idle levels (sclk=0, cs=1).
- Synchronization and edge detection:
  - sclk and cs pass through SYNC_STAGES flops, plus one history flop each for edge detection.
  - Input-to-edge latency: SYNC_STAGES+1 clk cycles.
  - sclk must have ≥4 clk cycles per half-period; faster sclk is out of spec.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - miso=0.
  - cs falling edge: shreg<=buf_data, bit_cnt<=0, word_cnt<=0, busy<=1, go to SHIFT.
  - buf_data already holds word 0, because buf_rewind was pulsed at the previous frame end or reset exit.
- SHIFT:
  - miso = shreg[DATA_WIDTH-1] at all times.
  - sclk rising edge: no action (master samples).
  - sclk falling edge, bit_cnt<DATA_WIDTH-1: shreg shifts left by 1, zero-filled; bit_cnt+1.
  - sclk falling edge, bit_cnt==DATA_WIDTH-1, word_cnt<FRAME_WORDS-1: pulse buf_oe, word_cnt+1, go to LOAD.
  - sclk falling edge, bit_cnt==DATA_WIDTH-1, word_cnt==FRAME_WORDS-1: go to DONE; frame_done pulses that cycle.
- LOAD:
  - Waits exactly 1 cycle after buf_oe for the buffer's registered output to update.
  - Then shreg<=buf_data, bit_cnt<=0, go to SHIFT.
  - The new MSB is on miso within 2 clk of the falling edge, well before the next rising sclk edge.
- DONE:
  - miso=0; extra sclk edges are ignored (no buf_oe, no wrap).
  - Remains until cs rises.
- cs rising edge, any non-IDLE state (normal end or mid-word abort):
  - buf_rewind pulses 1 cycle, busy<=0, miso<=0, go to IDLE.
  - A partial word is discarded; no frame_done on abort.
- After reset release: buf_rewind pulses once on the first cycle with rst==1.
- Simultaneous cs rise and sclk falling edge in the same cycle: cs wins, no buf_oe.
- cs falling edge while not IDLE: impossible by ordering (a rise is always seen first); no special handling.
- buf_oe total per complete frame: exactly FRAME_WORDS-1.

Optional Feature:
- Macro SPI_SERIALIZER_LSB_FIRST_EN.
- Defined: miso=shreg[0]; shreg shifts right, zero-filled. Word order and counts are unchanged.
- Undefined: MSB-first as above.

Decomposition:
- Shared package spi_pkg: state enum (IDLE/LOAD/SHIFT/DONE), SPI mode constant, helper for counter widths ($clog2 of DATA_WIDTH and FRAME_WORDS).
- One natural sub-module: spi_edge_sync.
  - Parameterised SYNC_STAGES; synchronizer plus rise/fall pulse outputs.
  - Instantiated twice (sclk, cs); reusable by the receive path.

Test Plan:
- Basic frame: DATA_WIDTH=8, FRAME_WORDS=3, buffer preloaded 0xA5,0x3C,0xFF; cs low, 24 sclk cycles at clk/10 -> master samples A5 3C FF MSB-first; buf_oe pulses exactly 2; frame_done once; buf_rewind on cs rise.
- Over-clocking: 32 extra sclk cycles after frame end -> miso stays 0, no buf_oe, busy stays 1 until cs rises.
- Mid-word abort: cs raised after 5 bits of word 1 -> no frame_done; buf_rewind pulses; next frame starts at word 0 (0xA5).
- Reset mid-frame: rst=0 for 1 cycle after 12 bits -> all outputs 0 next cycle; one buf_rewind pulse after release; subsequent frame correct.
- Collision: cs rise coincident (same synchronized cycle) with 8th sclk falling edge -> no buf_oe, IDLE.
- LSB-first build: macro defined, word 0x01 -> first sampled bit 1, then seven 0s.

Source files
------------

// File: rtl/spi_word_serializer_pkg.sv
// Shared types and helpers for the SPI slave datapath (serializer and receive path).
package spi_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} spi_state_e;

  // CPOL=0, CPHA=0: master samples on rising sclk, slave changes on falling sclk.
  localparam int SPI_MODE = 0;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_word_serializer_edge_sync.sv
// Multi-flop synchronizer for an asynchronous SPI pin with rise/fall pulse outputs.
module spi_edge_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_LVL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync <= {SYNC_STAGES{IDLE_LVL}};
      hist <= IDLE_LVL;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~hist;
  assign fall = ~sync[SYNC_STAGES-1] & hist;

endmodule

// File: rtl/spi_word_serializer.sv
// SPI mode-0 slave transmitter: shifts prefetched buffer words out on miso, one frame per cs.
// Define SPI_SERIALIZER_LSB_FIRST_EN to shift each word LSB-first instead of MSB-first.
module spi_word_serializer
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int FRAME_WORDS = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] buf_data,
  output logic                  buf_oe,
  output logic                  buf_rewind,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BW = cnt_w(DATA_WIDTH);
  localparam int WW = cnt_w(FRAME_WORDS);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(FRAME_WORDS - 1);

  logic sclk_fall, sclk_rise_unused, cs_rise, cs_fall;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .d(sclk), .rise(sclk_rise_unused), .fall(sclk_fall)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LVL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .d(cs), .rise(cs_rise), .fall(cs_fall)
  );

`ifdef SPI_SERIALIZER_LSB_FIRST_EN
  function automatic logic out_bit(input logic [DATA_WIDTH-1:0] w);
    return w[0];
  endfunction
  function automatic logic [DATA_WIDTH-1:0] shift_w(input logic [DATA_WIDTH-1:0] w);
    return w >> 1;
  endfunction
`else
  function automatic logic out_bit(input logic [DATA_WIDTH-1:0] w);
    return w[DATA_WIDTH-1];
  endfunction
  function automatic logic [DATA_WIDTH-1:0] shift_w(input logic [DATA_WIDTH-1:0] w);
    return w << 1;
  endfunction
`endif

  spi_state_e            state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BW-1:0]         bit_cnt;
  logic [WW-1:0]         word_cnt;
  logic                  load_wait;
  logic                  init_pend;

  // miso is registered and always tracks the bit the master will sample next.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      load_wait  <= 1'b0;
      init_pend  <= 1'b1;
      miso       <= 1'b0;
      buf_oe     <= 1'b0;
      buf_rewind <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      buf_oe     <= 1'b0;
      buf_rewind <= init_pend;
      frame_done <= 1'b0;
      init_pend  <= 1'b0;
      // cs release ends the frame from any state and beats a same-cycle sclk edge.
      if (state != IDLE && cs_rise) begin
        state      <= IDLE;
        buf_rewind <= 1'b1;
        busy       <= 1'b0;
        miso       <= 1'b0;
        load_wait  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            miso <= 1'b0;
            if (cs_fall) begin
              shreg    <= buf_data;
              miso     <= out_bit(buf_data);
              bit_cnt  <= '0;
              word_cnt <= '0;
              busy     <= 1'b1;
              state    <= SHIFT;
            end
          end
          SHIFT: begin
            if (sclk_fall) begin
              if (bit_cnt != BIT_LAST) begin
                shreg   <= shift_w(shreg);
                miso    <= out_bit(shift_w(shreg));
                bit_cnt <= bit_cnt + 1'b1;
              end else if (word_cnt != WORD_LAST) begin
                buf_oe    <= 1'b1;
                word_cnt  <= word_cnt + 1'b1;
                load_wait <= 1'b0;
                state     <= LOAD;
              end else begin
                frame_done <= 1'b1;
                miso       <= 1'b0;
                state      <= DONE;
              end
            end
          end
          LOAD: begin
            // First cycle: buffer registers the advance; second: its output is valid.
            if (!load_wait) begin
              load_wait <= 1'b1;
            end else begin
              shreg     <= buf_data;
              miso      <= out_bit(buf_data);
              bit_cnt   <= '0;
              load_wait <= 1'b0;
              state     <= SHIFT;
            end
          end
          DONE:    miso  <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_word_serializer.sv
// Bench for spi_word_serializer: behavioural SPI master plus word buffer, checked against a bit-order model.
module tb_spi_word_serializer;

  localparam int DW = 8;
  localparam int FW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sclk = 1'b0;
  logic          cs = 1'b1;
  logic          miso, buf_oe, buf_rewind, busy, frame_done;
  logic [DW-1:0] buf_data;

  int checks = 0;
  int errors = 0;
  int n_oe = 0, n_done = 0, n_rew = 0;

  always #5 clk = ~clk;

  spi_word_serializer #(.DATA_WIDTH(DW), .FRAME_WORDS(FW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .miso(miso), .buf_data(buf_data),
    .buf_oe(buf_oe), .buf_rewind(buf_rewind), .busy(busy), .frame_done(frame_done)
  );

  // Word buffer: address register advanced by buf_oe, cleared by buf_rewind.
  logic [DW-1:0] mem [FW];
  int            addr = 0;
  assign buf_data = mem[addr];
  always @(posedge clk) begin
    if (buf_rewind) addr <= 0;
    else if (buf_oe && addr < FW - 1) addr <= addr + 1;
  end

  always @(negedge clk) begin
    if (buf_oe)     n_oe++;
    if (frame_done) n_done++;
    if (buf_rewind) n_rew++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Bit i (0 = first on the wire) of word w as the master should see it.
  function automatic int exp_bit(input logic [DW-1:0] w, input int i);
`ifdef SPI_SERIALIZER_LSB_FIRST_EN
    return (int'(w) / (1 << i)) % 2;
`else
    return (int'(w) / (1 << (DW - 1 - i))) % 2;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One sclk period at clk/10; sample at the end of the high phase.
  task automatic sbit(output int b);
    sclk = 1'b1;
    tick(5);
    b = int'(miso);
    sclk = 1'b0;
    tick(5);
  endtask

  task automatic frame_check(input string tag, input int extra);
    int oe0, d0, r0, bad, b;
    oe0 = n_oe; d0 = n_done; r0 = n_rew; bad = 0;
    cs = 1'b0;
    tick(8);
    for (int w = 0; w < FW; w++)
      for (int i = 0; i < DW; i++) begin
        sbit(b);
        if (b != exp_bit(mem[w], i)) bad++;
      end
    chk({tag, " bad_bits"}, bad, 0);
    if (extra > 0) begin
      bad = 0;
      for (int i = 0; i < extra; i++) begin
        sbit(b);
        if (b != 0) bad++;
      end
      chk({tag, " overclk_miso_ones"}, bad, 0);
    end
    chk({tag, " busy_before_cs_rise"}, int'(busy), 1);
    cs = 1'b1;
    tick(8);
    chk({tag, " buf_oe_count"}, n_oe - oe0, FW - 1);
    chk({tag, " frame_done_count"}, n_done - d0, 1);
    chk({tag, " rewind_count"}, n_rew - r0, 1);
    chk({tag, " busy_after"}, int'(busy), 0);
  endtask

  typedef struct {
    logic [FW-1:0][DW-1:0] words;
    int                    extra;
  } vec_t;

  initial begin
    vec_t vt[4];
    int   oe0, d0, r0, b, bad;

    vt[0] = '{words: {8'hFF, 8'h3C, 8'hA5}, extra: 32};
    vt[1] = '{words: {8'h00, 8'h80, 8'h01}, extra: 0};
    vt[2] = '{words: {8'h55, 8'h00, 8'hFF}, extra: 3};
    vt[3] = '{words: {8'hBE, 8'hAD, 8'hDE}, extra: 0};
    for (int w = 0; w < FW; w++) mem[w] = vt[0].words[w];

    // Reset state and the single rewind pulse on release.
    tick(3);
    chk("reset_outputs", int'({miso, buf_oe, buf_rewind, busy, frame_done}), 0);
    rst = 1'b1;
    tick(6);
    chk("reset_exit_rewind", n_rew, 1);
    chk("idle_miso", int'(miso), 0);

    for (int v = 0; v < 4; v++) begin
      for (int w = 0; w < FW; w++) mem[w] = vt[v].words[w];
      frame_check($sformatf("vec%0d", v), vt[v].extra);
    end

    for (int r = 0; r < 4; r++) begin
      for (int w = 0; w < FW; w++) mem[w] = DW'($urandom);
      frame_check($sformatf("rand%0d", r), int'($urandom_range(0, 2)));
    end

    // Mid-word abort after 5 bits of word 1.
    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'hFF;
    oe0 = n_oe; d0 = n_done; r0 = n_rew; bad = 0;
    cs = 1'b0;
    tick(8);
    for (int i = 0; i < DW + 5; i++) begin
      sbit(b);
      if (b != exp_bit(mem[i / DW], i % DW)) bad++;
    end
    chk("abort bad_bits", bad, 0);
    cs = 1'b1;
    tick(8);
    chk("abort frame_done", n_done - d0, 0);
    chk("abort buf_oe", n_oe - oe0, 1);
    chk("abort rewind", n_rew - r0, 1);
    chk("abort busy", int'(busy), 0);
    frame_check("after_abort", 0);

    // Reset pulse after 12 bits.
    cs = 1'b0;
    tick(8);
    for (int i = 0; i < 12; i++) sbit(b);
    rst = 1'b0;
    cs = 1'b1;
    tick(1);
    chk("midreset_outputs", int'({miso, buf_oe, buf_rewind, busy, frame_done}), 0);
    r0 = n_rew;
    rst = 1'b1;
    tick(8);
    chk("midreset_rewind", n_rew - r0, 1);
    frame_check("after_reset", 0);

    // cs rise in the same cycle as the 8th falling sclk edge.
    oe0 = n_oe; d0 = n_done; r0 = n_rew;
    cs = 1'b0;
    tick(8);
    for (int i = 0; i < DW - 1; i++) sbit(b);
    sclk = 1'b1;
    tick(5);
    sclk = 1'b0;
    cs = 1'b1;
    tick(10);
    chk("collide buf_oe", n_oe - oe0, 0);
    chk("collide frame_done", n_done - d0, 0);
    chk("collide rewind", n_rew - r0, 1);
    chk("collide busy", int'(busy), 0);
    frame_check("after_collide", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
